// File: rtl/register_file_if.sv
// Register-file port bundle: two read ports, one write port and the commit counter.
interface register_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [CNT_W-1:0]  write_count;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write,
        input  read_data1, read_data2, write_count
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write,
        output read_data1, read_data2, write_count
    );
endinterface

// File: rtl/register_file.sv
// MIPS GPR file: 2 combinational read ports, 1 synchronous write port, r0 hardwired to zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    register_file_if.slave   bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = 16;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  write_count_q;
    logic [CNT_W-1:0]  write_count_d;
    logic              wr_en;

    // Writes to r0 are dropped entirely, including from the commit count.
    assign wr_en = bus.reg_write && (bus.write_reg != '0);

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (wr_en) begin
            regs_d[bus.write_reg] = bus.write_data;
            if (write_count_q != '1) begin
                write_count_d = write_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    // Read ports; forwarding is gated by rst so outputs stay zero during reset.
    always_comb begin
        bus.read_data1 = (bus.read_reg1 == '0) ? '0 : regs_q[bus.read_reg1];
        bus.read_data2 = (bus.read_reg2 == '0) ? '0 : regs_q[bus.read_reg2];
`ifdef REGFILE_BYPASS_EN
        if (!rst && wr_en && (bus.read_reg1 == bus.write_reg)) begin
            bus.read_data1 = bus.write_data;
        end
        if (!rst && wr_en && (bus.read_reg2 == bus.write_reg)) begin
            bus.read_data2 = bus.write_data;
        end
`endif
    end

    assign bus.write_count = write_count_q;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed table, reset corner sequences and a randomized run
// against an array model. Honors REGFILE_BYPASS_EN for same-cycle read expectations.
module tb_register_file;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    register_file_if bus ();
    register_file dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference state: plain array plus saturating counter.
    logic [31:0] m_regs [32];
    int unsigned m_count;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] pre1;
        logic [31:0] pre2;
        logic [31:0] post1;
        logic [31:0] post2;
        int unsigned cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (BYP && we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] sel(input logic [31:0] nb, input logic [31:0] byp);
        return BYP ? byp : nb;
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        bus.reg_write  = we;
        bus.write_reg  = wa;
        bus.write_data = wd;
        bus.read_reg1  = ra1;
        bus.read_reg2  = ra2;
    endtask

    task automatic idle();
        bus.reg_write = 1'b0;
    endtask

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_count = 0;
        bus.reg_write = 0; bus.write_reg = 0; bus.write_data = 0;
        bus.read_reg1 = 0; bus.read_reg2 = 0;

        // Directed vectors, applied from a clean reset.
        vecs[0] = '{1, 31, 32'h1234_5678, 31, 31, sel(0, 32'h1234_5678), sel(0, 32'h1234_5678),
                    32'h1234_5678, 32'h1234_5678, 1};
        vecs[1] = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1};
        vecs[2] = '{1, 9, 32'h1, 9, 0, sel(0, 32'h1), 0, 32'h1, 0, 2};
        vecs[3] = '{1, 9, 32'h2, 1, 9, 0, sel(32'h1, 32'h2), 0, 32'h2, 3};
        vecs[4] = '{0, 9, 32'h55, 9, 9, 32'h2, 32'h2, 32'h2, 32'h2, 3};
        vecs[5] = '{1, 15, 32'hA, 15, 31, sel(0, 32'hA), 32'h1234_5678, 32'hA, 32'h1234_5678, 4};
        vecs[6] = '{1, 31, 32'hB, 15, 31, 32'hA, sel(32'h1234_5678, 32'hB), 32'hA, 32'hB, 5};
        vecs[7] = '{1, 15, 32'hA, 15, 31, 32'hA, 32'hB, 32'hA, 32'hB, 6};
        vecs[8] = '{1, 31, 32'hB, 15, 31, 32'hA, 32'hB, 32'hA, 32'hB, 7};

        // Power-on reset.
        rst = 1'b1;
        #12;
        chk("por_rd1", bus.read_data1, 0);
        chk("por_cnt", 32'(bus.write_count), 0);
        @(negedge clk); rst = 1'b0;

        // Reset mid-run after writing r5.
        drive(1, 5, 32'hDEAD_BEEF, 5, 0);
        @(posedge clk); #1; idle();
        chk("r5_written", bus.read_data1, 32'hDEAD_BEEF);
        chk("r5_cnt", 32'(bus.write_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rd1", bus.read_data1, 0);
        chk("rst_async_cnt", 32'(bus.write_count), 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
            #1;
            chk($sformatf("vec%0d_pre1", i), bus.read_data1, vecs[i].pre1);
            chk($sformatf("vec%0d_pre2", i), bus.read_data2, vecs[i].pre2);
            @(posedge clk); #1; idle();
            chk($sformatf("vec%0d_post1", i), bus.read_data1, vecs[i].post1);
            chk($sformatf("vec%0d_post2", i), bus.read_data2, vecs[i].post2);
            chk($sformatf("vec%0d_cnt", i), 32'(bus.write_count), vecs[i].cnt);
        end

        // Full sweep after the dest-mux alternation.
        for (int a = 0; a < 32; a++) begin
            logic [31:0] e;
            e = (a == 15) ? 32'hA : (a == 31) ? 32'hB : (a == 9) ? 32'h2 : 32'h0;
            @(negedge clk);
            bus.read_reg1 = 5'(a);
            bus.read_reg2 = 5'(31 - a);
            #1;
            chk($sformatf("sweep_r%0d", a), bus.read_data1, e);
        end

        // Reset rising on the same edge as a write to r3.
        drive(1, 3, 32'h77, 3, 3);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("rst_edge_r3", bus.read_data1, 0);
        chk("rst_edge_cnt", 32'(bus.write_count), 0);
        @(negedge clk);
        idle();
        chk("rst_high_rd2", bus.read_data2, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_edge_r3_after", bus.read_data1, 0);

        // Randomized run against the model; addresses biased toward collisions.
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_count = 0;
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [4:0]  wa, ra1, ra2;
            logic [31:0] wd;
            we  = ($urandom % 4) != 0;
            wa  = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ra1 = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ra2 = ($urandom % 2) ? wa : 5'($urandom);
            wd  = $urandom;
            drive(we, wa, wd, ra1, ra2);
            #1;
            chk("rnd_pre1", bus.read_data1, m_read(ra1, we, wa, wd));
            chk("rnd_pre2", bus.read_data2, m_read(ra2, we, wa, wd));
            @(posedge clk); #1; idle();
            if (we && wa != 5'd0) begin
                m_regs[wa] = wd;
                if (m_count < 32'hFFFF) m_count++;
            end
            chk("rnd_post1", bus.read_data1, m_read(ra1, 1'b0, wa, wd));
            chk("rnd_post2", bus.read_data2, m_read(ra2, 1'b0, wa, wd));
            chk("rnd_cnt", 32'(bus.write_count), m_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
